// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data access block.
// Holds the request FSM encoding and the access-size codes used on the data bus.
// Size helper maps the reserved size code 3 onto a full word access.
package mem_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    WAIT   = 3'd2,
    DONE   = 3'd3,
    CANCEL = 3'd4
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Size code 3 has no bus meaning; treat it as a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] num);
    return (num == 2'd3) ? SZ_WORD : num;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data bus: store strobes/replicated data and load extract/extend.
// Purely combinational, zero latency.
// No flow control of its own; the parent FSM decides when the outputs are used.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  st_addr_lo_i,
  input  logic [1:0]  st_size_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  st_wstrb_o,
  output logic [31:0] st_wdata_o,
  input  logic [1:0]  ld_addr_lo_i,
  input  logic [1:0]  ld_size_i,
  input  logic        ld_sext_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] ld_shift;

  // Store side: enable the addressed lanes and replicate the low bytes across all lanes.
  always_comb begin
    st_wstrb_o = 4'b1111;
    st_wdata_o = st_data_i;
    case (st_size_i)
      SZ_BYTE: begin
        st_wstrb_o = 4'b0001 << st_addr_lo_i;
        st_wdata_o = {4{st_data_i[7:0]}};
      end
      SZ_HALF: begin
        st_wstrb_o = st_addr_lo_i[1] ? 4'b1100 : 4'b0011;
        st_wdata_o = {2{st_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Load side: move the addressed lane down to bit 0, then sign- or zero-extend.
  always_comb begin
    ld_shift = ld_rdata_i >> {ld_addr_lo_i, 3'b000};
    case (ld_size_i)
      SZ_BYTE: ld_data_o = {{24{ld_sext_i & ld_shift[7]}}, ld_shift[7:0]};
      SZ_HALF: ld_data_o = {{16{ld_sext_i & ld_shift[15]}}, ld_shift[15:0]};
      default: ld_data_o = ld_shift;
    endcase
  end

endmodule

// File: rtl/mem_data_access.sv
// MEM-stage data access: turns the held EX->MEM fields into one SRAM-like request and a WB result.
// Non-memory ops complete in the same cycle; loads/stores take >= 3 cycles (accept, addr_ok, data_ok).
// Holds the EX->MEM register via mem_ready_go while a request is open or WB stalls; flush cancels.
module mem_data_access
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              in_dram_re,
  input  logic              in_dram_we,
  input  logic              in_has_ex,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [1:0]        in_rd_num,
  input  logic              in_rd_sext,
  input  logic [1:0]        in_wr_num,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic              wb_allowin,
  output logic              mem_ready_go,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [3:0]        data_wstrb,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_result
);

  state_t            state_q;
  logic              req_q;
  logic              wr_q;
  logic [1:0]        size_q;
  logic [3:0]        wstrb_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              sext_q;
  logic [DATA_W-1:0] result_q;

  logic              mem_op;
  logic [1:0]        st_size;
  logic [3:0]        st_wstrb;
  logic [DATA_W-1:0] st_wdata;
  logic [DATA_W-1:0] ld_data;

  assign mem_op  = in_valid & (in_dram_re | in_dram_we) & ~in_has_ex;
  assign st_size = norm_size(in_wr_num);

  mem_lane_align u_align (
    .st_addr_lo_i (in_addr[1:0]),
    .st_size_i    (st_size),
    .st_data_i    (in_wdata),
    .st_wstrb_o   (st_wstrb),
    .st_wdata_o   (st_wdata),
    .ld_addr_lo_i (addr_q[1:0]),
    .ld_size_i    (size_q),
    .ld_sext_i    (sext_q),
    .ld_rdata_i   (data_rdata),
    .ld_data_o    (ld_data)
  );

  // Request FSM: one outstanding access, with a CANCEL state to swallow a flushed response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      wr_q     <= 1'b0;
      size_q   <= 2'd0;
      wstrb_q  <= 4'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      sext_q   <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_op && !flush) begin
            state_q <= REQ;
            req_q   <= 1'b1;
            wr_q    <= in_dram_we;
            size_q  <= in_dram_we ? st_size : norm_size(in_rd_num);
            wstrb_q <= in_dram_we ? st_wstrb : 4'd0;
            addr_q  <= in_addr;
            wdata_q <= st_wdata;
            sext_q  <= in_rd_sext;
          end
        end
        REQ: begin
          // An unaccepted request can simply be withdrawn; an accepted one must be drained.
          if (data_addr_ok) begin
            req_q   <= 1'b0;
            state_q <= flush ? CANCEL : WAIT;
          end else if (flush) begin
            req_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        WAIT: begin
          if (data_data_ok) begin
            if (flush) begin
              state_q <= IDLE;
            end else begin
              state_q  <= DONE;
              result_q <= wr_q ? in_alu_result : ld_data;
            end
          end else if (flush) begin
            state_q <= CANCEL;
          end
        end
        DONE: begin
          if (flush || wb_allowin) state_q <= IDLE;
        end
        CANCEL: begin
          if (data_data_ok) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshake back to EX->MEM and result toward WB; flush always squashes out_valid.
  always_comb begin
    mem_ready_go = 1'b0;
    out_valid    = 1'b0;
    out_result   = result_q;
    case (state_q)
      IDLE: begin
        if (!in_valid) begin
          mem_ready_go = 1'b1;
        end else if (!mem_op) begin
          out_valid    = 1'b1;
          out_result   = in_alu_result;
          mem_ready_go = wb_allowin;
        end else begin
          // A flushed memory op is dead; let the register drop it.
          mem_ready_go = flush;
        end
      end
      DONE: begin
        out_valid    = 1'b1;
        mem_ready_go = wb_allowin;
      end
      default: ;
    endcase
    if (flush) out_valid = 1'b0;
  end

  assign data_req   = req_q;
  assign data_wr    = wr_q;
  assign data_size  = size_q;
  assign data_wstrb = wstrb_q;
  assign data_addr  = addr_q;
  assign data_wdata = wdata_q;

endmodule

// File: tb/tb_mem_data_access.sv
// Randomized bench for mem_data_access with a transaction-level reference model.
// Stimulus tasks drive whole load/store/ALU transactions and publish per-cycle expectations.
// A single negedge compare process checks the DUT against those expectations.
module tb_mem_data_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid, in_dram_re, in_dram_we, in_has_ex;
  logic [31:0] in_addr, in_wdata, in_alu_result;
  logic [1:0]  in_rd_num, in_wr_num;
  logic        in_rd_sext;
  logic        wb_allowin;
  logic        mem_ready_go;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        out_valid;
  logic [31:0] out_result;

  always #5 clk = ~clk;

  mem_data_access #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_dram_re(in_dram_re), .in_dram_we(in_dram_we),
    .in_has_ex(in_has_ex), .in_addr(in_addr), .in_wdata(in_wdata),
    .in_rd_num(in_rd_num), .in_rd_sext(in_rd_sext), .in_wr_num(in_wr_num),
    .in_alu_result(in_alu_result), .wb_allowin(wb_allowin),
    .mem_ready_go(mem_ready_go), .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata), .out_valid(out_valid), .out_result(out_result)
  );

  int n_vec = 0;
  int n_err = 0;

  // Per-cycle expectations published by the stimulus tasks.
  logic        chk_en = 1'b0;
  logic        e_req, e_wr, e_ov, e_rg;
  logic [1:0]  e_size;
  logic [3:0]  e_wstrb;
  logic [31:0] e_addr, e_wdata, e_res;
  // Hand-computed literals: 1 = store request fields, 2 = load result.
  int          pin_kind = 0;
  logic [1:0]  pin_size;
  logic [3:0]  pin_wstrb;
  logic [31:0] pin_wdata, pin_res;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference rules written from byte arithmetic, not from the lane mux.
  function automatic int nbytes(input logic [1:0] sz);
    return 1 << ((sz == 2'd3) ? 2 : int'(sz));
  endfunction

  function automatic logic [3:0] m_wstrb(input logic [1:0] sz, input logic [31:0] a);
    int n = nbytes(sz);
    return 4'(((1 << n) - 1) << a[1:0]);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] d);
    int n = nbytes(sz);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic sx,
                                         input logic [31:0] a, input logic [31:0] rd);
    int n = nbytes(sz);
    logic [31:0] v, mask;
    v = rd >> (8 * int'(a[1:0]));
    if (n < 4) begin
      mask = (32'd1 << (8 * n)) - 32'd1;
      v = v & mask;
      if (sx && v[8*n-1]) v = v | ~mask;
    end
    return v;
  endfunction

  // Compare process: mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("mem_ready_go", 32'(mem_ready_go), 32'(e_rg));
      check("data_req", 32'(data_req), 32'(e_req));
      check("out_valid", 32'(out_valid), 32'(e_ov));
      if (e_req) begin
        check("data_wr", 32'(data_wr), 32'(e_wr));
        check("data_size", 32'(data_size), 32'(e_size));
        check("data_addr", data_addr, e_addr);
        if (e_wr) begin
          check("data_wstrb", 32'(data_wstrb), 32'(e_wstrb));
          check("data_wdata", data_wdata, e_wdata);
        end
        if (pin_kind == 1) begin
          check("pin_size", 32'(data_size), 32'(pin_size));
          check("pin_wstrb", 32'(data_wstrb), 32'(pin_wstrb));
          check("pin_wdata", data_wdata, pin_wdata);
        end
      end
      if (e_ov) begin
        check("out_result", out_result, e_res);
        if (pin_kind == 2) check("pin_result", out_result, pin_res);
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_after();
    in_valid = 1'b0; flush = 1'b0;
    e_req = 1'b0; e_ov = 1'b0; e_rg = 1'b1;
    cycle();
  endtask

  // Drain a response that belongs to a flushed instruction.
  task automatic cancel_drain(input int n);
    in_valid = 1'b0; flush = 1'b0;
    e_req = 1'b0; e_ov = 1'b0; e_rg = 1'b0;
    data_rdata = 32'hDEAD_BEEF;
    for (int k = 0; k < n; k++) cycle();
    data_data_ok = 1'b1;
    cycle();
    data_data_ok = 1'b0;
    idle_after();
  endtask

  task automatic do_bubble();
    in_valid = 1'b0; in_dram_re = 1'($urandom); in_dram_we = 1'($urandom);
    in_alu_result = $urandom; wb_allowin = 1'($urandom); flush = 1'b0;
    e_req = 1'b0; e_ov = 1'b0; e_rg = 1'b1;
    cycle();
  endtask

  task automatic do_alu(input bit has_ex, input logic [31:0] alu, input int stall);
    in_valid = 1'b1; in_has_ex = has_ex; in_alu_result = alu; in_addr = $urandom;
    in_dram_re = has_ex ? 1'b1 : 1'b0; in_dram_we = 1'b0; flush = 1'b0;
    e_req = 1'b0; e_ov = 1'b1; e_res = alu;
    for (int s = 0; s < stall; s++) begin
      wb_allowin = 1'b0; e_rg = 1'b0; cycle();
    end
    wb_allowin = 1'b1; e_rg = 1'b1; cycle();
    in_has_ex = 1'b0; e_ov = 1'b0;
  endtask

  // fph: 0 none, 1 flush in REQ before accept, 2 flush with addr_ok,
  //      3 flush in WAIT before data_ok, 4 flush with data_ok, 5 flush in DONE.
  task automatic do_mem(input bit st, input logic [31:0] a, input logic [1:0] sz, input bit sx,
                        input logic [31:0] wd, input logic [31:0] alu, input logic [31:0] rd,
                        input int aok_d, input int dok_d, input int stall, input int fph);
    logic [1:0] nsz;
    nsz = (sz == 2'd3) ? 2'd2 : sz;
    in_valid = 1'b1; in_dram_re = !st; in_dram_we = st; in_has_ex = 1'b0;
    in_addr = a; in_wdata = wd; in_rd_num = sz; in_wr_num = sz; in_rd_sext = sx;
    in_alu_result = alu; flush = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
    wb_allowin = 1'($urandom);
    e_req = 1'b0; e_ov = 1'b0; e_rg = 1'b0;
    cycle();
    e_req = 1'b1; e_wr = st; e_size = nsz; e_addr = a;
    e_wstrb = m_wstrb(nsz, a); e_wdata = m_wdata(nsz, wd);
    if (fph == 1) begin
      flush = 1'b1; cycle(); idle_after(); return;
    end
    for (int k = 0; k < aok_d; k++) begin
      wb_allowin = 1'($urandom); cycle();
    end
    data_addr_ok = 1'b1; flush = (fph == 2); cycle();
    data_addr_ok = 1'b0; e_req = 1'b0;
    if (fph == 2) begin
      cancel_drain(dok_d); return;
    end
    if (fph == 3) begin
      flush = 1'b1; cycle(); cancel_drain(2); return;
    end
    for (int k = 0; k < dok_d; k++) cycle();
    data_data_ok = 1'b1; data_rdata = rd; flush = (fph == 4); cycle();
    data_data_ok = 1'b0; data_rdata = $urandom;
    if (fph == 4) begin
      idle_after(); return;
    end
    e_ov = 1'b1; e_res = st ? alu : m_load(nsz, sx, a, rd);
    if (fph == 5) begin
      flush = 1'b1; wb_allowin = 1'b0; e_ov = 1'b0; e_rg = 1'b0; cycle();
      idle_after(); return;
    end
    for (int s = 0; s < stall; s++) begin
      wb_allowin = 1'b0; e_rg = 1'b0; cycle();
    end
    wb_allowin = 1'b1; e_rg = 1'b1; cycle();
    e_ov = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_req"}, 32'(data_req), 32'd0);
    check({tag, "_wr"}, 32'(data_wr), 32'd0);
    check({tag, "_size"}, 32'(data_size), 32'd0);
    check({tag, "_wstrb"}, 32'(data_wstrb), 32'd0);
    check({tag, "_addr"}, data_addr, 32'd0);
    check({tag, "_wdata"}, data_wdata, 32'd0);
    check({tag, "_ovalid"}, 32'(out_valid), 32'd0);
    check({tag, "_result"}, out_result, 32'd0);
    check({tag, "_ready_go"}, 32'(mem_ready_go), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    int          kind, fph;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_dram_re = 1'b0; in_dram_we = 1'b0;
    in_has_ex = 1'b0; in_addr = '0; in_wdata = '0; in_rd_num = '0; in_rd_sext = 1'b0;
    in_wr_num = '0; in_alu_result = '0; wb_allowin = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
    e_req = 1'b0; e_wr = 1'b0; e_ov = 1'b0; e_rg = 1'b1; e_size = '0;
    e_wstrb = '0; e_addr = '0; e_wdata = '0; e_res = '0;
    cycle(); cycle();
    rst = 1'b0;
    check_reset_state("reset");
    chk_en = 1'b1;

    // ld.b at byte 3, sign-extended; result visible three cycles after accept.
    pin_kind = 2; pin_res = 32'hFFFF_FF80;
    do_mem(0, 32'h0000_1003, 2'd0, 1, 32'h0, 32'h5555_5555, 32'h80FF_FF7F, 0, 0, 0, 0);
    pin_kind = 0;
    // st.h at upper half.
    pin_kind = 1; pin_size = 2'd1; pin_wstrb = 4'b1100; pin_wdata = 32'h1234_1234;
    do_mem(1, 32'h0000_2002, 2'd1, 0, 32'hABCD_1234, 32'h0000_0777, 32'h0, 0, 1, 0, 0);
    pin_kind = 0;
    // addr_ok withheld three cycles.
    do_mem(0, 32'h0000_3000, 2'd2, 0, 32'h0, 32'h0, 32'hCAFE_F00D, 3, 1, 0, 0);
    // flush in WAIT, late response dropped, then a fresh load with its own data.
    do_mem(0, 32'h0000_4000, 2'd2, 0, 32'h0, 32'h0, 32'h1111_1111, 0, 0, 0, 3);
    do_mem(0, 32'h0000_4001, 2'd0, 0, 32'h0, 32'h0, 32'h0000_A500, 0, 0, 0, 0);
    // WB stalls two cycles in DONE.
    do_mem(0, 32'h0000_5002, 2'd1, 1, 32'h0, 32'h0, 32'h8001_7FFF, 0, 0, 2, 0);
    // Exception-flagged load bypasses memory.
    do_alu(1, 32'h1111_2222, 0);
    do_alu(0, 32'h3333_4444, 1);
    do_bubble();

    // Synchronous reset while waiting for a response.
    in_valid = 1'b1; in_dram_re = 1'b1; in_dram_we = 1'b0; in_has_ex = 1'b0;
    in_addr = 32'h0000_6004; in_rd_num = 2'd2; wb_allowin = 1'b1;
    e_req = 1'b0; e_ov = 1'b0; e_rg = 1'b0;
    cycle();
    e_req = 1'b1; e_wr = 1'b0; e_size = 2'd2; e_addr = 32'h0000_6004;
    data_addr_ok = 1'b1; cycle(); data_addr_ok = 1'b0;
    e_req = 1'b0; rst = 1'b1; in_valid = 1'b0;
    cycle();
    rst = 1'b0; e_rg = 1'b1;
    check_reset_state("rst_wait");
    cycle();

    for (int t = 0; t < 160; t++) begin
      kind = $urandom_range(0, 9);
      if (kind < 2) begin
        do_bubble();
      end else if (kind < 4) begin
        do_alu(1'($urandom), $urandom, $urandom_range(0, 2));
      end else begin
        sz = 2'($urandom);
        a = $urandom;
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz >= 2'd2) a[1:0] = 2'b00;
        fph = ($urandom_range(0, 9) < 7) ? 0 : $urandom_range(1, 5);
        do_mem(1'($urandom), a, sz, 1'($urandom), $urandom, $urandom, $urandom,
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), fph);
      end
    end
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
